// File: rtl/fetch_queue_pkg.sv
// Shared opcode header for the core: base opcodes and the canonical NOP.
// Fetch and decode both import this so the NOP encoding has a single definition.
package fetch_queue_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {instruction, pc} entries with a flush
// that takes priority over push and pop.
module fetch_fifo #(
  parameter  int W     = 46,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // NOTE: the storage array has no reset; count and pointers alone decide
  // what is valid, so the RAM can map onto plain flops or a register file.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues I-cache reads under a credit limit,
// queues returning instructions, and handles redirect by flush-and-kill.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int                ADDR_W   = 14,
  parameter  int                DEPTH    = 4,
  parameter  logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int                CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       icache_addr,
  output logic              icache_re,
  input  logic [31:0]       instruction,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic [CW-1:0]     occupancy
);

  logic [ADDR_W-1:0]    fetch_pc;
  logic [ADDR_W-1:0]    inflight_pc;
  logic                 inflight_q;
  logic                 pop_req;
  logic                 capture;
  logic [CW:0]          need;
  logic [32+ADDR_W-1:0] head;
  logic                 queue_empty;

  assign queue_empty = (occupancy == '0);
  assign inst_valid  = !queue_empty && !stall;
  assign pop_req     = inst_valid && inst_ready;
  assign capture     = inflight_q && !redirect;

  // Entries already held plus the one still returning must leave room for a new read.
  assign need      = {1'b0, occupancy} - (CW+1)'(pop_req) + (CW+1)'(inflight_q);
  assign icache_re = !rst && !stall && !redirect && (need < (CW+1)'(DEPTH));

  assign icache_addr = 32'(fetch_pc);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_q  <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight_q <= icache_re;
      if (icache_re) inflight_pc <= fetch_pc;
      if (redirect)
        fetch_pc <= redirect_pc & ~ADDR_W'(3);
      else if (icache_re)
        fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  fetch_fifo #(
    .W     (32 + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data ({instruction, inflight_pc}),
    .pop       (pop_req && !redirect),
    .flush     (redirect),
    .head      (head),
    .count     (occupancy)
  );

  // An empty queue presents a NOP tagged with the address about to be fetched.
  assign inst    = queue_empty ? NOP_INST : head[32+ADDR_W-1:ADDR_W];
  assign inst_pc = queue_empty ? fetch_pc : head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: I-cache model, PC scoreboard, and a second
// instance with a top-of-space reset PC to exercise wrap-around.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_ready;

  logic [31:0]       icache_addr;
  logic              icache_re;
  logic [31:0]       instruction;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic [CW-1:0]     occupancy;

  logic [31:0]       w_icache_addr;
  logic              w_icache_re;
  logic [31:0]       w_instruction;
  logic              w_inst_valid;
  logic [31:0]       w_inst;
  logic [ADDR_W-1:0] w_inst_pc;
  logic [CW-1:0]     w_occupancy;

  int errors = 0;
  int checks = 0;
  logic [ADDR_W-1:0] sb[$];

  fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(14'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .icache_addr (icache_addr),
    .icache_re   (icache_re),
    .instruction (instruction),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .occupancy   (occupancy)
  );

  fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(14'h3FFC)) dut_w (
    .clk         (clk),
    .rst         (rst),
    .icache_addr (w_icache_addr),
    .icache_re   (w_icache_re),
    .instruction (w_instruction),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc ('0),
    .inst_valid  (w_inst_valid),
    .inst        (w_inst),
    .inst_pc     (w_inst_pc),
    .inst_ready  (1'b1),
    .occupancy   (w_occupancy)
  );

  function automatic logic [31:0] inst_of(input logic [ADDR_W-1:0] a);
    return 32'h5A00_0000 | 32'(a);
  endfunction

  // One-cycle-latency instruction memory for each instance.
  always @(posedge clk) begin
    if (icache_re)   instruction   <= inst_of(icache_addr[ADDR_W-1:0]);
    if (w_icache_re) w_instruction <= inst_of(w_icache_addr[ADDR_W-1:0]);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Sample at the falling edge; every accepted instruction is scored in order.
  task automatic sample();
    logic [ADDR_W-1:0] e;
    @(negedge clk);
    if (inst_valid && inst_ready && !redirect) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected: observed pc=%h expected none", inst_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", 32'(inst_pc), 32'(e));
        check("sb_inst", inst, inst_of(e));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    advance();
    advance();

    // Held in reset
    sample();
    check("rst_re",       32'(icache_re),  32'd0);
    check("rst_valid",    32'(inst_valid), 32'd0);
    check("rst_occ",      32'(occupancy),  32'd0);
    check("rst_inst",     inst,            NOP_INST);
    check("rst_addr",     icache_addr,     32'h0);
    check("rst_w_addr",   w_icache_addr,   32'h3FFC);
    advance();

    // Reset release, free-running stream
    rst = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(ADDR_W'(4 * i));
    for (int c = 0; c < 6; c++) begin
      sample();
      if (c == 0) begin
        check("c0_re",     32'(icache_re), 32'd1);
        check("c0_addr",   icache_addr,    32'h0);
        check("c0_valid",  32'(inst_valid), 32'd0);
        check("w_c0_addr", w_icache_addr,  32'h3FFC);
      end
      if (c == 1) begin
        check("c1_addr",   icache_addr,    32'h4);
        check("c1_valid",  32'(inst_valid), 32'd0);
        check("w_wrap",    w_icache_addr,  32'h0);
      end
      if (c >= 2) check("stream_valid", 32'(inst_valid), 32'd1);
      if (c == 2) begin
        check("w_c2_pc",   32'(w_inst_pc), 32'h3FFC);
        check("w_c2_inst", w_inst,         inst_of(14'h3FFC));
      end
      if (c == 3) check("w_c3_pc", 32'(w_inst_pc), 32'h0);
      if (c < 5) advance();
    end

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("arst_re",    32'(icache_re),  32'd0);
    check("arst_valid", 32'(inst_valid), 32'd0);
    check("arst_occ",   32'(occupancy),  32'd0);
    check("arst_inst",  inst,            NOP_INST);
    check("arst_addr",  icache_addr,     32'h0);
    check("sb_drain1",  32'(sb.size()),  32'd0);
    advance();

    // Restart with decode blocked: queue fills, fetch holds at 0x10
    rst = 1'b0; inst_ready = 1'b0;
    for (int i = 0; i < 9; i++) sb.push_back(ADDR_W'(4 * i));
    for (int c = 0; c < 10; c++) begin
      sample();
      if (c == 4) begin
        check("fill_re",   32'(icache_re), 32'd0);
        check("fill_addr", icache_addr,    32'h10);
      end
      if (c == 9) begin
        check("full_occ",   32'(occupancy),  32'd4);
        check("full_re",    32'(icache_re),  32'd0);
        check("full_addr",  icache_addr,     32'h10);
        check("full_valid", 32'(inst_valid), 32'd1);
      end
      advance();
    end

    // Release: ordered drain with no gap
    inst_ready = 1'b1;
    for (int c = 10; c < 17; c++) begin
      sample();
      check("drain_valid", 32'(inst_valid), 32'd1);
      if (c == 10) begin
        check("rel_re",   32'(icache_re), 32'd1);
        check("rel_addr", icache_addr,    32'h10);
      end
      if (c == 16) check("steady_occ", 32'(occupancy), 32'd3);
      advance();
    end

    // Three-cycle stall mid-stream
    stall = 1'b1;
    for (int c = 17; c < 20; c++) begin
      sample();
      check("stall_valid", 32'(inst_valid), 32'd0);
      check("stall_re",    32'(icache_re),  32'd0);
      if (c == 18) check("stall_capture_occ", 32'(occupancy), 32'd4);
      advance();
    end
    stall = 1'b0;
    for (int c = 20; c < 22; c++) begin
      sample();
      check("resume_valid", 32'(inst_valid), 32'd1);
      advance();
    end

    // Redirect with a pop and a returning response in the same cycle
    redirect = 1'b1; redirect_pc = 14'h0203;
    for (int i = 0; i < 4; i++) sb.push_back(ADDR_W'(14'h0200 + 4 * i));
    sample();
    check("redir_occ_before", 32'(occupancy), 32'd3);
    check("redir_re",         32'(icache_re), 32'd0);
    advance();
    redirect = 1'b0;

    sample();
    check("post_redir_occ",   32'(occupancy),  32'd0);
    check("post_redir_re",    32'(icache_re),  32'd1);
    check("post_redir_addr",  icache_addr,     32'h200);
    check("post_redir_valid", 32'(inst_valid), 32'd0);
    check("empty_inst",       inst,            NOP_INST);
    check("empty_pc",         32'(inst_pc),    32'h200);
    advance();

    sample();
    check("t2_valid", 32'(inst_valid), 32'd0);
    check("t2_addr",  icache_addr,     32'h204);
    advance();

    sample();
    check("t3_valid", 32'(inst_valid), 32'd1);
    advance();
    for (int c = 0; c < 3; c++) begin
      sample();
      advance();
    end

    inst_ready = 1'b0;
    sample();
    check("sb_drain_final", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, the fetch PC width in bytes-address bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, the queue entries; power of two, at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 0, the first fetch address after reset.
REQ-004 The block SHALL have one clock and an asynchronous active-high reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-005 The block SHALL have icache_addr output 32, the read address, zero-extended fetch PC.
REQ-006 The block SHALL have icache_re output 1, the read strobe; data returns exactly one cycle later.
REQ-007 The block SHALL have instruction input 32, the read data, valid in the cycle after icache_re.
REQ-008 The block SHALL have stall input 1, the global freeze.
REQ-009 The block SHALL have redirect input 1 and redirect_pc input ADDR_W, the branch/jump target request.
REQ-010 The block SHALL have inst_valid output 1, inst output 32, and inst_pc output ADDR_W, the queue head to decode.
REQ-011 The block SHALL have inst_ready input 1, meaning decode accepts the head this cycle.
REQ-012 The block SHALL have occupancy output clog2(DEPTH+1), the current entry count.

Function
REQ-013 Fetch PC register: icache_addr SHALL equal the fetch PC; the fetch PC SHALL advance by 4 per issued read, wrapping modulo 2^ADDR_W.
REQ-014 Issue rule: icache_re=1 SHALL hold when stall=0, redirect=0, rst=0 and (occupancy - pop + inflight) < DEPTH; pop = inst_valid & inst_ready; inflight = read issued last cycle and not killed.
REQ-015 Capture: a non-killed response SHALL be written into the queue at the end of its return cycle with its PC; capture SHALL occur even when stall=1, and the credit rule guarantees space.
REQ-016 Head: inst_valid SHALL be (occupancy>0) & ~stall; when the queue is empty, inst SHALL be 32'h00000013 (NOP) and inst_pc SHALL be the fetch PC.
REQ-017 Pop: inst_valid & inst_ready SHALL remove the head at the clock edge; no pop SHALL occur while stall=1.
REQ-018 Latency: a read issued in cycle t SHALL appear as inst_valid in cycle t+2, with no bypass.
REQ-019 Throughput: with inst_ready held high and no stall, DEPTH>=2 SHALL sustain one instruction per cycle.
REQ-020 Redirect: in the cycle of redirect=1, the queue SHALL be flushed (occupancy to 0), the in-flight read SHALL be killed, and the fetch PC SHALL be loaded with {redirect_pc[ADDR_W-1:2],2'b00}; issue SHALL resume the next cycle, so the first target instruction is valid at t+3.
REQ-021 Redirect priority: redirect SHALL override stall, pop and capture in the same cycle; a simultaneous pop SHALL be discarded and a simultaneous response SHALL be dropped.
REQ-022 Full queue: with occupancy=DEPTH and no pop, icache_re SHALL be 0 and the fetch PC SHALL hold.
REQ-023 Simultaneous pop and capture SHALL leave occupancy unchanged, preserving order.

Reset
REQ-024 While rst=1: icache_re=0, inst_valid=0, occupancy=0, inflight killed, fetch PC=RESET_PC, inst=NOP.
REQ-025 Reset asserted mid-operation SHALL discard all queued and in-flight instructions asynchronously.
REQ-026 After reset deassertion, the first read of RESET_PC SHALL issue in the first cycle, and it SHALL be valid two cycles later.

Structure
REQ-027 The NOP encoding and the opcode constants SHALL live in the shared opcode header used by the core.
REQ-028 The circular buffer SHALL be one sub-module, fetch_fifo (data+PC width, DEPTH, push/pop/flush, count), with the issue/credit/kill logic in fetch_queue.

Verification
REQ-029 Reset release, inst_ready=1, DEPTH=4: inst_pc sequence 0,4,8,12 SHALL appear on consecutive cycles starting two cycles after the first icache_re.
REQ-030 inst_ready=0 for 10 cycles: occupancy SHALL saturate at 4, then icache_re=0 and icache_addr held at 0x10; on release, ordered drain 0..0xC SHALL be followed by 0x10 with no gap.
REQ-031 Redirect to 0x0203 while occupancy=3 with a read in flight: occupancy SHALL be 0 next cycle, the killed data SHALL never appear, and the first valid inst_pc SHALL be 0x0200 at t+3.
REQ-032 stall=1 for 3 cycles during streaming: inst_valid=0 and icache_re=0 throughout, one in-flight response SHALL be captured, and the sequence SHALL resume without loss or duplication.
REQ-033 Redirect together with inst_ready=1 and a returning response in the same cycle: neither the popped nor the returning instruction SHALL be visible afterwards; RESET_PC=0x3FFC SHALL show wrap-around to 0x0000 after one fetch.
REQ-034 rst pulse mid-stream, asynchronous between edges: outputs SHALL go to reset values immediately, and the stream SHALL restart at RESET_PC.
